// File: rtl/ecc_apb_slave.sv
// ---------------------------------------------------------------------------
// ecc_apb_slave
//
// APB3 responder and register file sitting in front of the ECC accelerator
// core. Holds the operation configuration (CTRL, DATA_IN, CODEWORD_WIDTH,
// NOISE), fires a one-cycle start pulse at the core on every valid CTRL
// write, tracks the operation in flight and captures the core's result
// (DATA_OUT, NUM_OF_ERRORS) when it reports completion.
//
// Register map (byte addresses, compared over the full paddr width):
//   0x00 CTRL           RW  [1:0] 0=encode 1=decode 2=full channel 3=reserved
//   0x04 DATA_IN        RW  [DATA_WIDTH-1:0]
//   0x08 CODEWORD_WIDTH RW  [1:0] 0=8b 1=16b 2=32b
//   0x0C NOISE          RW  [DATA_WIDTH-1:0]
//   0x10 DATA_OUT       RO  last captured core result
//   0x14 NUM_OF_ERRORS  RO  [1:0] last captured error count
//
// Config writes (0x00-0x0C) issued while the core is busy are held off with
// wait states until the core signals done; every other access completes
// with zero wait states.
//
// Build option:
//   ECC_APB_SLVERR_EN  when defined, pslverr flags unmapped addresses,
//                      writes to read-only registers and writes of the
//                      reserved value 3 to CTRL / CODEWORD_WIDTH; such
//                      writes are discarded. When undefined, pslverr is 0
//                      and those writes behave as ordinary writes.
//
// Ports:
//   clk, reset          clock (rising edge) and synchronous active-high reset
//   paddr/psel/penable/pwrite/pwdata   APB request from the bus master
//   prdata/pready/pslverr              APB response (prdata registered)
//   ctrl_o, data_in_o, codeword_width_o, noise_o   configuration to the core
//   start_o             one-cycle start pulse to the core
//   busy_o              core operation in flight
//   core_done_i, core_data_out_i, core_num_err_i   completion from the core
// ---------------------------------------------------------------------------
module ecc_apb_slave #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AMBA_ADDR_WIDTH-1:0] paddr,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [AMBA_WORD-1:0]       pwdata,
    output logic [AMBA_WORD-1:0]       prdata,
    output logic                       pready,
    output logic                       pslverr,
    output logic [1:0]                 ctrl_o,
    output logic [DATA_WIDTH-1:0]      data_in_o,
    output logic [1:0]                 codeword_width_o,
    output logic [DATA_WIDTH-1:0]      noise_o,
    output logic                       start_o,
    input  logic                       core_done_i,
    input  logic [DATA_WIDTH-1:0]      core_data_out_i,
    input  logic [1:0]                 core_num_err_i,
    output logic                       busy_o
);

`ifdef ECC_APB_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CTRL    = AMBA_ADDR_WIDTH'(32'h00);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_DATA_IN = AMBA_ADDR_WIDTH'(32'h04);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CW      = AMBA_ADDR_WIDTH'(32'h08);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_NOISE   = AMBA_ADDR_WIDTH'(32'h0C);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_DOUT    = AMBA_ADDR_WIDTH'(32'h10);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_NERR    = AMBA_ADDR_WIDTH'(32'h14);

    // APB phase encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // Registers
    logic [1:0]            state_q, state_d;
    logic [1:0]            ctrl_q;
    logic [DATA_WIDTH-1:0] data_in_q;
    logic [1:0]            codeword_width_q;
    logic [DATA_WIDTH-1:0] noise_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic [1:0]            num_err_q;
    logic [AMBA_WORD-1:0]  prdata_q, prdata_d;
    logic                  start_q;
    logic                  busy_q;

    // Combinational decode
    logic [1:0] phase;
    logic       in_access;
    logic       sel_ctrl, sel_din, sel_cw, sel_noise, sel_dout, sel_nerr;
    logic       mapped, cfg_addr;
    logic       done_accept, busy_eff;
    logic       err_cond, slv_err, xfer_done, wr_en, ctrl_start;

    // Phase of the current bus cycle. state_q remembers the previous cycle:
    // SETUP, or an ACCESS that was stalled. A completed ACCESS collapses to
    // IDLE so that a lone penable cycle after it is not taken as a new access;
    // back-to-back transfers go ACCESS -> SETUP through the master's own
    // setup cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        phase = ST_IDLE;
        if (psel) begin
            if (!penable) begin
                phase = ST_SETUP;
            end else if (state_q == ST_SETUP || state_q == ST_ACCESS) begin
                phase = ST_ACCESS;
            end
        end
    end

    assign in_access = (phase == ST_ACCESS);

    assign sel_ctrl  = (paddr == ADDR_CTRL);
    assign sel_din   = (paddr == ADDR_DATA_IN);
    assign sel_cw    = (paddr == ADDR_CW);
    assign sel_noise = (paddr == ADDR_NOISE);
    assign sel_dout  = (paddr == ADDR_DOUT);
    assign sel_nerr  = (paddr == ADDR_NERR);
    assign cfg_addr  = sel_ctrl | sel_din | sel_cw | sel_noise;
    assign mapped    = cfg_addr | sel_dout | sel_nerr;

    // A done pulse counts only while an operation is in flight and not in
    // the start cycle itself (start wins that collision).
    assign done_accept = core_done_i && busy_q && !start_q;
    // Busy as it will be after this edge's done handling; lets a stalled
    // config write complete in the very cycle the core reports done.
    assign busy_eff    = busy_q && !done_accept;

    assign pready = in_access && !(pwrite && cfg_addr && busy_eff);

    assign err_cond = !mapped
                    || (pwrite && (sel_dout || sel_nerr))
                    || (pwrite && sel_ctrl && (pwdata[1:0] == 2'd3))
                    || (pwrite && sel_cw   && (pwdata[1:0] == 2'd3));
    assign slv_err  = SLVERR_EN && err_cond;

    assign xfer_done  = in_access && pready;
    assign pslverr    = xfer_done && slv_err;
    assign wr_en      = xfer_done && pwrite && !slv_err;
    assign ctrl_start = wr_en && sel_ctrl && (pwdata[1:0] != 2'd3);

    assign state_d = xfer_done ? ST_IDLE : phase;

    always_comb begin
        prdata_d = '0;
        if (sel_ctrl)  prdata_d = AMBA_WORD'(ctrl_q);
        if (sel_din)   prdata_d = AMBA_WORD'(data_in_q);
        if (sel_cw)    prdata_d = AMBA_WORD'(codeword_width_q);
        if (sel_noise) prdata_d = AMBA_WORD'(noise_q);
        if (sel_dout)  prdata_d = AMBA_WORD'(data_out_q);
        if (sel_nerr)  prdata_d = AMBA_WORD'(num_err_q);
    end

    // NOTE: state is updated with non-blocking assignments only, and the
    // reset branch is evaluated on the clock edge (synchronous reset).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            ctrl_q           <= '0;
            data_in_q        <= '0;
            codeword_width_q <= '0;
            noise_q          <= '0;
            data_out_q       <= '0;
            num_err_q        <= '0;
            prdata_q         <= '0;
            start_q          <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= ctrl_start;

            // A new start sets busy even when a done clears it on this edge.
            if (ctrl_start) begin
                busy_q <= 1'b1;
            end else if (done_accept) begin
                busy_q <= 1'b0;
            end

            if (done_accept) begin
                data_out_q <= core_data_out_i;
                num_err_q  <= core_num_err_i;
            end

            if (wr_en) begin
                if (sel_ctrl)  ctrl_q           <= pwdata[1:0];
                if (sel_din)   data_in_q        <= pwdata[DATA_WIDTH-1:0];
                if (sel_cw)    codeword_width_q <= pwdata[1:0];
                if (sel_noise) noise_q          <= pwdata[DATA_WIDTH-1:0];
            end

            // Read data is captured in the setup phase and held through access.
            if (phase == ST_SETUP && !pwrite) begin
                prdata_q <= prdata_d;
            end
        end
    end

    assign prdata           = prdata_q;
    assign ctrl_o           = ctrl_q;
    assign data_in_o        = data_in_q;
    assign codeword_width_o = codeword_width_q;
    assign noise_o          = noise_q;
    assign start_o          = start_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_ecc_apb_slave.sv
// ---------------------------------------------------------------------------
// tb_ecc_apb_slave
//
// Self-checking bench for ecc_apb_slave. Acts as APB master and as the ECC
// core. A transaction-level reference model (register values, busy flag,
// start count) predicts read data, wait states, pslverr and register
// outputs for directed scenarios and a randomized transaction stream.
// Honours ECC_APB_SLVERR_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_ecc_apb_slave;

`ifdef ECC_APB_SLVERR_EN
    localparam bit SLV = 1'b1;
`else
    localparam bit SLV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [1:0]  ctrl_o;
    logic [31:0] data_in_o;
    logic [1:0]  codeword_width_o;
    logic [31:0] noise_o;
    logic        start_o;
    logic        core_done_i;
    logic [31:0] core_data_out_i;
    logic [1:0]  core_num_err_i;
    logic        busy_o;

    always #5 clk = ~clk;

    ecc_apb_slave dut (
        .clk              (clk),
        .reset            (reset),
        .paddr            (paddr),
        .psel             (psel),
        .penable          (penable),
        .pwrite           (pwrite),
        .pwdata           (pwdata),
        .prdata           (prdata),
        .pready           (pready),
        .pslverr          (pslverr),
        .ctrl_o           (ctrl_o),
        .data_in_o        (data_in_o),
        .codeword_width_o (codeword_width_o),
        .noise_o          (noise_o),
        .start_o          (start_o),
        .core_done_i      (core_done_i),
        .core_data_out_i  (core_data_out_i),
        .core_num_err_i   (core_num_err_i),
        .busy_o           (busy_o)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Start pulse monitor: counts pulses and flags any pulse longer than one cycle.
    int   start_cnt    = 0;
    logic start_prev   = 1'b0;
    logic start_double = 1'b0;
    always @(posedge clk) begin
        if (start_o) start_cnt <= start_cnt + 1;
        if (start_o && start_prev) start_double <= 1'b1;
        start_prev <= start_o;
    end

    // ---------------- reference model ----------------
    logic [1:0]  m_ctrl, m_cw, m_nerr;
    logic [31:0] m_din, m_noise, m_dout;
    bit          m_busy;
    int          exp_starts = 0;

    logic [31:0] exp_rdata, got_rdata, got_noise_mid;
    bit          exp_err, got_err;
    int          exp_waits, got_waits;

    task automatic model_reset();
        m_ctrl = 0; m_cw = 0; m_nerr = 0;
        m_din = 0; m_noise = 0; m_dout = 0;
        m_busy = 0;
    endtask

    function automatic bit is_cfg(input logic [19:0] a);
        return (a == 20'h0) || (a == 20'h4) || (a == 20'h8) || (a == 20'hC);
    endfunction

    function automatic bit is_mapped(input logic [19:0] a);
        return is_cfg(a) || (a == 20'h10) || (a == 20'h14);
    endfunction

    function automatic logic [31:0] m_read(input logic [19:0] a);
        case (a)
            20'h00:  return {30'd0, m_ctrl};
            20'h04:  return m_din;
            20'h08:  return {30'd0, m_cw};
            20'h0C:  return m_noise;
            20'h10:  return m_dout;
            20'h14:  return {30'd0, m_nerr};
            default: return 32'd0;
        endcase
    endfunction

    // Predict one APB transfer. done_at: access cycle index in which the core
    // pulses done (-1 = none).
    task automatic model_xfer(input bit wr, input logic [19:0] a, input logic [31:0] d,
                              input int done_at, input logic [31:0] dv, input logic [1:0] nv);
        bit stall;
        exp_rdata = m_read(a);
        stall     = m_busy && wr && is_cfg(a);
        exp_waits = stall ? done_at : 0;
        if (m_busy && done_at >= 0 && done_at <= exp_waits) begin
            m_dout = dv; m_nerr = nv; m_busy = 0;
        end
        exp_err = SLV && (!is_mapped(a)
                          || (wr && (a == 20'h10 || a == 20'h14))
                          || (wr && a == 20'h0 && d[1:0] == 2'd3)
                          || (wr && a == 20'h8 && d[1:0] == 2'd3));
        if (wr && !exp_err) begin
            case (a)
                20'h00: begin
                    m_ctrl = d[1:0];
                    if (d[1:0] != 2'd3) begin
                        exp_starts++;
                        m_busy = 1;
                    end
                end
                20'h04: m_din   = d;
                20'h08: m_cw    = d[1:0];
                20'h0C: m_noise = d;
                default: ;
            endcase
        end
    endtask

    // ---------------- bus / core drivers ----------------
    // Entered and left #1 after a rising edge. One setup cycle, access cycles
    // until pready, then one idle cycle (in which done_post drives core_done_i).
    task automatic apb_xfer(input bit wr, input logic [19:0] a, input logic [31:0] d,
                            input int done_at, input logic [31:0] dv, input logic [1:0] nv,
                            input bit done_post);
        logic rdy;
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1;
        got_waits = 0;
        got_noise_mid = noise_o;
        forever begin
            core_done_i = (done_at == got_waits);
            core_data_out_i = dv; core_num_err_i = nv;
            @(negedge clk);
            got_rdata = prdata; got_err = pslverr; rdy = pready;
            @(posedge clk); #1;
            core_done_i = 0;
            if (rdy) break;
            got_waits++;
            if (got_waits > 20) begin
                n_total++;
                $display("FAIL xfer_timeout addr=%h: pready still 0 after %0d waits, required 1", a, got_waits);
                break;
            end
        end
        psel = 0; penable = 0; pwrite = 0;
        core_done_i = done_post; core_data_out_i = dv; core_num_err_i = nv;
        @(posedge clk); #1;
        core_done_i = 0;
    endtask

    task automatic run_xfer(input bit wr, input logic [19:0] a, input logic [31:0] d,
                            input int done_at, input logic [31:0] dv, input logic [1:0] nv,
                            input bit done_post);
        model_xfer(wr, a, d, done_at, dv, nv);
        apb_xfer(wr, a, d, done_at, dv, nv, done_post);
    endtask

    task automatic idle_done(input logic [31:0] dv, input logic [1:0] nv);
        if (m_busy) begin
            m_dout = dv; m_nerr = nv; m_busy = 0;
        end
        core_done_i = 1; core_data_out_i = dv; core_num_err_i = nv;
        @(posedge clk); #1;
        core_done_i = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [19:0] a;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if ({ctrl_o, codeword_width_o} !== 4'd0) $display("FAIL rst_ctrl_cw: got %h required 0", {ctrl_o, codeword_width_o}); else n_pass++;
        n_total++; if (data_in_o !== 32'd0) $display("FAIL rst_data_in: got %h required 0", data_in_o); else n_pass++;
        n_total++; if (noise_o !== 32'd0) $display("FAIL rst_noise: got %h required 0", noise_o); else n_pass++;
        n_total++; if (prdata !== 32'd0) $display("FAIL rst_prdata: got %h required 0", prdata); else n_pass++;
        n_total++; if ({start_o, busy_o} !== 2'b00) $display("FAIL rst_start_busy: got %b required 00", {start_o, busy_o}); else n_pass++;
        n_total++; if ({pready, pslverr} !== 2'b00) $display("FAIL rst_pready_pslverr: got %b required 00", {pready, pslverr}); else n_pass++;
        reset = 0;
        model_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            a = 20'(i * 4);
            run_xfer(0, a, 0, -1, 0, 0, 0);
            n_total++; if (got_rdata !== 32'd0) $display("FAIL rst_read[%h]: got %h required 0", a, got_rdata); else n_pass++;
        end
    endtask

    task automatic test_encode();
        int s0;
        run_xfer(1, 20'h04, 32'h0000000B, -1, 0, 0, 0);
        run_xfer(1, 20'h08, 32'h0, -1, 0, 0, 0);
        s0 = start_cnt;
        run_xfer(1, 20'h00, 32'h0, -1, 0, 0, 0);
        n_total++; if (ctrl_o !== 2'd0) $display("FAIL enc_ctrl: got %0d required 0", ctrl_o); else n_pass++;
        n_total++; if (data_in_o !== 32'hB) $display("FAIL enc_data_in: got %h required b", data_in_o); else n_pass++;
        n_total++; if (start_cnt !== s0 + 1) $display("FAIL enc_start_count: got %0d required %0d", start_cnt - s0, 1); else n_pass++;
        n_total++; if (start_o !== 1'b0) $display("FAIL enc_start_width: got %b required 0 after one cycle", start_o); else n_pass++;
        n_total++; if (busy_o !== 1'b1) $display("FAIL enc_busy: got %b required 1", busy_o); else n_pass++;
        idle_done(32'h5B, 2'd0);
        n_total++; if (busy_o !== 1'b0) $display("FAIL enc_busy_clear: got %b required 0", busy_o); else n_pass++;
        run_xfer(0, 20'h10, 0, -1, 0, 0, 0);
        n_total++; if (got_rdata !== 32'h5B) $display("FAIL enc_data_out: got %h required 5b", got_rdata); else n_pass++;
        run_xfer(0, 20'h14, 0, -1, 0, 0, 0);
        n_total++; if (got_rdata !== 32'h0) $display("FAIL enc_num_err: got %h required 0", got_rdata); else n_pass++;
    endtask

    task automatic test_busy_stall();
        run_xfer(1, 20'h00, 32'h1, -1, 0, 0, 0);
        idle_done(32'h77, 2'd1);
        run_xfer(1, 20'h00, 32'h1, -1, 0, 0, 0);
        n_total++; if (busy_o !== 1'b1) $display("FAIL stall_busy: got %b required 1", busy_o); else n_pass++;
        run_xfer(0, 20'h14, 0, -1, 0, 0, 0);
        n_total++; if (got_waits !== 0) $display("FAIL stall_read_waits: got %0d required 0", got_waits); else n_pass++;
        n_total++; if (got_rdata !== 32'd1) $display("FAIL stall_read_stale: got %h required 1", got_rdata); else n_pass++;
        run_xfer(1, 20'h0C, 32'h3, 3, 32'h99, 2'd2, 0);
        n_total++; if (got_waits !== 3) $display("FAIL stall_waits: got %0d required 3", got_waits); else n_pass++;
        n_total++; if (got_noise_mid !== 32'd0) $display("FAIL stall_noise_early: got %h required 0", got_noise_mid); else n_pass++;
        n_total++; if (noise_o !== 32'h3) $display("FAIL stall_noise: got %h required 3", noise_o); else n_pass++;
        n_total++; if (busy_o !== 1'b0) $display("FAIL stall_busy_clear: got %b required 0", busy_o); else n_pass++;
        run_xfer(0, 20'h10, 0, -1, 0, 0, 0);
        n_total++; if (got_rdata !== 32'h99) $display("FAIL stall_data_out: got %h required 99", got_rdata); else n_pass++;
    endtask

    task automatic test_collision();
        run_xfer(1, 20'h00, 32'h2, -1, 32'hDEAD, 2'd1, 1);
        n_total++; if (busy_o !== 1'b1) $display("FAIL coll_busy: got %b required 1", busy_o); else n_pass++;
        run_xfer(0, 20'h10, 0, -1, 0, 0, 0);
        n_total++; if (got_rdata !== 32'h99) $display("FAIL coll_data_out_held: got %h required 99", got_rdata); else n_pass++;
        idle_done(32'h1234, 2'd1);
        n_total++; if (busy_o !== 1'b0) $display("FAIL coll_busy_clear: got %b required 0", busy_o); else n_pass++;
        run_xfer(0, 20'h10, 0, -1, 0, 0, 0);
        n_total++; if (got_rdata !== 32'h1234) $display("FAIL coll_data_out: got %h required 1234", got_rdata); else n_pass++;
    endtask

    task automatic test_reserved();
        int s0;
        logic [1:0] c0, w0;
        s0 = start_cnt;
        c0 = ctrl_o;
        run_xfer(1, 20'h00, 32'h3, -1, 0, 0, 0);
        n_total++; if (start_cnt !== s0) $display("FAIL rsv_ctrl_start: got %0d pulses required 0", start_cnt - s0); else n_pass++;
        n_total++; if (got_err !== SLV) $display("FAIL rsv_ctrl_pslverr: got %b required %b", got_err, SLV); else n_pass++;
        n_total++; if (ctrl_o !== (SLV ? c0 : 2'd3)) $display("FAIL rsv_ctrl_value: got %0d required %0d", ctrl_o, SLV ? c0 : 2'd3); else n_pass++;
        n_total++; if (busy_o !== 1'b0) $display("FAIL rsv_ctrl_busy: got %b required 0", busy_o); else n_pass++;
        w0 = codeword_width_o;
        run_xfer(1, 20'h08, 32'h3, -1, 0, 0, 0);
        n_total++; if (got_err !== SLV) $display("FAIL rsv_cw_pslverr: got %b required %b", got_err, SLV); else n_pass++;
        n_total++; if (codeword_width_o !== (SLV ? w0 : 2'd3)) $display("FAIL rsv_cw_value: got %0d required %0d", codeword_width_o, SLV ? w0 : 2'd3); else n_pass++;
    endtask

    task automatic test_unmapped();
        run_xfer(0, 20'h18, 0, -1, 0, 0, 0);
        n_total++; if (got_rdata !== 32'd0) $display("FAIL unm_read: got %h required 0", got_rdata); else n_pass++;
        n_total++; if (got_err !== SLV) $display("FAIL unm_read_pslverr: got %b required %b", got_err, SLV); else n_pass++;
        run_xfer(1, 20'h10, 32'hFFFF, -1, 0, 0, 0);
        n_total++; if (got_err !== SLV) $display("FAIL ro_write_pslverr: got %b required %b", got_err, SLV); else n_pass++;
        run_xfer(0, 20'h10, 0, -1, 0, 0, 0);
        n_total++; if (got_rdata !== 32'h1234) $display("FAIL ro_write_ignored: got %h required 1234", got_rdata); else n_pass++;
    endtask

    task automatic test_random();
        logic [19:0] pool [9] = '{20'h00, 20'h04, 20'h08, 20'h0C, 20'h10, 20'h14, 20'h18, 20'h02, 20'h80010};
        logic [19:0] a;
        logic [31:0] d, dv;
        logic [1:0]  nv;
        bit          wr;
        int          done_at;
        for (int i = 0; i < 60; i++) begin
            a  = pool[$urandom_range(0, 8)];
            wr = 1'($urandom_range(0, 1));
            d  = $urandom();
            dv = $urandom();
            nv = 2'($urandom_range(0, 2));
            if (m_busy && wr && is_cfg(a)) done_at = $urandom_range(0, 3);
            else done_at = ($urandom_range(0, 2) == 0) ? 0 : -1;
            run_xfer(wr, a, d, done_at, dv, nv, 0);
            n_total++; if (got_waits !== exp_waits) $display("FAIL rnd%0d_waits a=%h: got %0d required %0d", i, a, got_waits, exp_waits); else n_pass++;
            n_total++; if (got_err !== exp_err) $display("FAIL rnd%0d_pslverr a=%h: got %b required %b", i, a, got_err, exp_err); else n_pass++;
            if (!wr) begin
                n_total++; if (got_rdata !== exp_rdata) $display("FAIL rnd%0d_rdata a=%h: got %h required %h", i, a, got_rdata, exp_rdata); else n_pass++;
            end
            n_total++; if ({ctrl_o, codeword_width_o} !== {m_ctrl, m_cw}) $display("FAIL rnd%0d_ctrl_cw: got %h required %h", i, {ctrl_o, codeword_width_o}, {m_ctrl, m_cw}); else n_pass++;
            n_total++; if ({data_in_o, noise_o} !== {m_din, m_noise}) $display("FAIL rnd%0d_din_noise: got %h required %h", i, {data_in_o, noise_o}, {m_din, m_noise}); else n_pass++;
            n_total++; if (busy_o !== m_busy) $display("FAIL rnd%0d_busy: got %b required %b", i, busy_o, m_busy); else n_pass++;
            n_total++; if (start_cnt !== exp_starts) $display("FAIL rnd%0d_starts: got %0d required %0d", i, start_cnt, exp_starts); else n_pass++;
        end
        n_total++; if (start_double !== 1'b0) $display("FAIL start_pulse_width: got multi-cycle pulse, required single"); else n_pass++;
        for (int k = 4; k <= 20; k += 4) begin
            a = 20'(k);
            run_xfer(0, a, 0, -1, 0, 0, 0);
            n_total++; if (got_rdata !== exp_rdata) $display("FAIL rnd_final_read[%h]: got %h required %h", a, got_rdata, exp_rdata); else n_pass++;
        end
    endtask

    task automatic test_reset_midop();
        run_xfer(1, 20'h04, 32'hA5A5, m_busy ? 0 : -1, 32'h5, 2'd1, 0);
        run_xfer(1, 20'h00, 32'h1, -1, 0, 0, 0);
        n_total++; if (busy_o !== 1'b1) $display("FAIL midrst_busy_before: got %b required 1", busy_o); else n_pass++;
        psel = 1; penable = 0; pwrite = 0; paddr = 20'h10;
        reset = 1; core_done_i = 1; core_data_out_i = 32'hABCD; core_num_err_i = 2'd2;
        @(posedge clk); #1;
        reset = 0; core_done_i = 0; psel = 0;
        model_reset();
        @(posedge clk); #1;
        n_total++; if ({busy_o, ctrl_o} !== 3'd0) $display("FAIL midrst_busy_ctrl: got %b required 000", {busy_o, ctrl_o}); else n_pass++;
        n_total++; if (data_in_o !== 32'd0) $display("FAIL midrst_data_in: got %h required 0", data_in_o); else n_pass++;
        run_xfer(0, 20'h10, 0, -1, 0, 0, 0);
        n_total++; if (got_rdata !== 32'd0) $display("FAIL midrst_data_out: got %h required 0", got_rdata); else n_pass++;
    endtask

    initial begin
        reset = 1; paddr = 0; psel = 0; penable = 0; pwrite = 0; pwdata = 0;
        core_done_i = 0; core_data_out_i = 0; core_num_err_i = 0;
        model_reset();
        test_reset();
        test_encode();
        test_busy_stall();
        test_collision();
        test_reserved();
        test_unmapped();
        test_random();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
